// File: rtl/master_addr_sender.sv
// master_addr_sender: serialises a latched slave address to the decoder, waits for ack,
// and tracks the connected/split phases of the bus transaction.
module master_addr_sender #(
  parameter int DEVICE_ADDR_WIDTH = 4,
  parameter int ACK_TIMEOUT       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DEVICE_ADDR_WIDTH-1:0] dev_addr,
  input  logic                         bus_grant,
  input  logic                         ack,
  input  logic                         ssplit,
  input  logic                         split_grant,
  input  logic                         done,
  output logic                         mwdata,
  output logic                         mvalid,
  output logic                         busy,
  output logic                         connected,
  output logic                         addr_err
);
  localparam int CW = $clog2(DEVICE_ADDR_WIDTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CONN  = 3'd3;
  localparam logic [2:0] S_SPLIT = 3'd4;
  logic [2:0]                   r_state;
  logic [2:0]                   w_next;
  logic [CW-1:0]                r_bit;
  logic [TW-1:0]                r_tmo;
  logic [DEVICE_ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]                w_nbit;
  logic [DEVICE_ADDR_WIDTH-1:0] w_shift;
  logic                         w_accept;
  logic                         w_last;
  logic                         w_expire;
  assign w_accept = (r_state == S_IDLE) && start && bus_grant;
  assign w_last   = r_bit == CW'(DEVICE_ADDR_WIDTH - 1);
  assign w_expire = r_tmo == TW'(ACK_TIMEOUT - 1);
  assign w_nbit   = r_bit + CW'(1);
  assign w_shift  = r_addr >> w_nbit;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_ADDR : S_IDLE;
      S_ADDR:  w_next = w_last ? S_WAIT : S_ADDR;
      S_WAIT:  w_next = ack ? S_CONN : w_expire ? S_IDLE : S_WAIT;
      S_CONN:  w_next = done ? S_IDLE : ssplit ? S_SPLIT : S_CONN;
      S_SPLIT: w_next = split_grant ? S_CONN : S_SPLIT;
      default: w_next = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit     <= '0;
      r_tmo     <= '0;
      r_addr    <= '0;
      mwdata    <= 1'b0;
      mvalid    <= 1'b0;
      busy      <= 1'b0;
      connected <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bit     <= (r_state == S_ADDR) ? w_nbit : '0;
      r_tmo     <= (r_state == S_WAIT) ? r_tmo + TW'(1) : '0;
      r_addr    <= w_accept ? dev_addr : r_addr;
      mwdata    <= w_accept ? dev_addr[0] : (r_state == S_ADDR && !w_last) ? w_shift[0] : 1'b0;
      mvalid    <= (w_next == S_ADDR) || (w_next == S_WAIT) || (w_next == S_CONN);
      busy      <= w_next != S_IDLE;
      connected <= w_next == S_CONN;
      addr_err  <= (r_state == S_WAIT) && !ack && w_expire;
    end
  end
endmodule

// File: tb/tb_master_addr_sender.sv
// tb_master_addr_sender: directed scoreboard bench; each step queues the output vector
// {mvalid,mwdata,busy,connected,addr_err} expected after the next rising edge.
module tb_master_addr_sender;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, bus_grant, ack, ssplit, split_grant, done;
  logic [3:0] dev_addr;
  logic       mwdata, mvalid, busy, connected, addr_err;
  int         checks = 0;
  int         failures = 0;
  logic [4:0] q[$];
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_REQ  = 6'b110000;
  localparam logic [5:0] I_ACK  = 6'b001000;
  localparam logic [5:0] I_SPL  = 6'b000100;
  localparam logic [5:0] I_SG   = 6'b000010;
  localparam logic [5:0] I_DONE = 6'b000001;
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_WAIT  = 5'b10100;
  localparam logic [4:0] O_CONN  = 5'b10110;
  localparam logic [4:0] O_SPLIT = 5'b00100;
  localparam logic [4:0] O_ERR   = 5'b00001;
  master_addr_sender #(.DEVICE_ADDR_WIDTH(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .bus_grant(bus_grant),
    .ack(ack), .ssplit(ssplit), .split_grant(split_grant), .done(done),
    .mwdata(mwdata), .mvalid(mvalid), .busy(busy), .connected(connected), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] abit(input logic b);
    return {1'b1, b, 3'b100};
  endfunction
  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {mvalid, mwdata, busy, connected, addr_err};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic [5:0] iv, input logic [3:0] da, input logic [4:0] exp, input string tag);
    {start, bus_grant, ack, ssplit, split_grant, done} = iv;
    dev_addr = da;
    q.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, q.pop_front());
  endtask
  initial begin
    rst = 1'b1;
    {start, bus_grant, ack, ssplit, split_grant, done} = I_NONE;
    dev_addr = 4'h0;
    #1 check("reset", O_IDLE);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(I_REQ, 4'b0110, abit(1'b0), "a_bit0");
    cyc(I_REQ, 4'b1111, abit(1'b1), "a_bit1_start_ignored");
    cyc(I_ACK, 4'b0000, abit(1'b1), "a_bit2_ack_ignored");
    cyc(I_NONE, 4'b0000, abit(1'b0), "a_bit3");
    cyc(I_NONE, 4'b0000, O_WAIT, "a_wait_entry");
    cyc(I_NONE, 4'b0000, O_WAIT, "a_wait");
    cyc(I_ACK, 4'b0000, O_CONN, "a_connect");
    cyc(I_NONE, 4'b0000, O_CONN, "a_hold");
    cyc(I_DONE, 4'b0000, O_IDLE, "a_done");
    cyc(I_REQ, 4'b0011, abit(1'b1), "t_bit0");
    cyc(I_NONE, 4'b0000, abit(1'b1), "t_bit1");
    cyc(I_NONE, 4'b0000, abit(1'b0), "t_bit2");
    cyc(I_NONE, 4'b0000, abit(1'b0), "t_bit3");
    for (int i = 0; i < 8; i++) cyc(I_NONE, 4'b0000, O_WAIT, "t_wait");
    cyc(I_NONE, 4'b0000, O_ERR, "t_addr_err");
    cyc(I_NONE, 4'b0000, O_IDLE, "t_err_one_cycle");
    cyc(I_REQ, 4'b1010, abit(1'b0), "p_bit0");
    cyc(I_NONE, 4'b0000, abit(1'b1), "p_bit1");
    cyc(I_NONE, 4'b0000, abit(1'b0), "p_bit2");
    cyc(I_NONE, 4'b0000, abit(1'b1), "p_bit3");
    for (int i = 0; i < 8; i++) cyc(I_NONE, 4'b0000, O_WAIT, "p_wait");
    cyc(I_ACK, 4'b0000, O_CONN, "p_ack_beats_timeout");
    cyc(I_SPL, 4'b0000, O_SPLIT, "s_enter_split");
    for (int i = 0; i < 4; i++) cyc(I_REQ | I_ACK, 4'b1111, O_SPLIT, "s_hold_split");
    cyc(I_SG, 4'b0000, O_CONN, "s_split_grant");
    cyc(I_NONE, 4'b0000, O_CONN, "s_no_resend");
    cyc(I_DONE | I_SPL, 4'b0000, O_IDLE, "d_done_beats_split");
    cyc(I_NONE, 4'b0000, O_IDLE, "d_stay_idle");
    for (int i = 0; i < 3; i++) cyc(6'b100000, 4'b0101, O_IDLE, "g_no_grant");
    cyc(I_REQ, 4'b0101, abit(1'b1), "g_bit0");
    cyc(I_NONE, 4'b0000, abit(1'b0), "g_bit1");
    cyc(I_NONE, 4'b0000, abit(1'b1), "g_bit2");
    #2 rst = 1'b1;
    #1 check("r_async_addr", O_IDLE);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(I_NONE, 4'b0000, O_IDLE, "r_idle_after");
    cyc(I_REQ, 4'b0101, abit(1'b1), "r_bit0");
    cyc(I_NONE, 4'b0000, abit(1'b0), "r_bit1");
    cyc(I_NONE, 4'b0000, abit(1'b1), "r_bit2");
    cyc(I_NONE, 4'b0000, abit(1'b0), "r_bit3");
    cyc(I_NONE, 4'b0000, O_WAIT, "r_wait");
    #2 rst = 1'b1;
    #1 check("r_async_wait", O_IDLE);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc(I_NONE, 4'b0000, O_IDLE, "r_no_addr_err");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
